// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - multiply/divide unit opcodes, FSM states and default latencies
package md_pkg;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;
   localparam int MD_CNT_W       = 8;

   typedef logic [MD_CNT_W-1:0] md_cnt_t;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_long(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - E-stage to multiply/divide unit request and HI/LO result bundle
interface md_ctrl_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, rs_val, rt_val, input busy, hi, lo);
   modport slave  (input start, md_op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/md_alu.sv
// rtl/md_alu.sv - combinational 64-bit multiply / divide result generator
module md_alu
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_zero
);

   logic        a_neg, b_neg, is_signed;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      is_signed = (op == MD_DIV);
      a_neg     = is_signed & a[31];
      b_neg     = is_signed & b[31];
      a_mag     = a_neg ? (~a + 32'd1) : a;
      b_mag     = b_neg ? (~b + 32'd1) : b;
      div_zero  = (b == 32'd0);
      q_mag     = div_zero ? 32'd0 : (a_mag / b_mag);
      r_mag     = div_zero ? 32'd0 : (a_mag % b_mag);
      q         = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      r         = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   always_comb begin
      result = 64'd0;
      case (op)
         MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         MD_MULTU: result = {32'd0, a} * {32'd0, b};
         MD_DIV,
         MD_DIVU:  result = {r, q};
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multi-cycle HI/LO multiply/divide sequencer
module md_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   md_ctrl_if.slave   md
);

   md_state_e   state;
   md_cnt_t     cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        busy_q;
   logic [31:0] hi_q, lo_q;
   logic [63:0] alu_result;
   logic        alu_div_zero;

   md_alu u_alu (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .result   (alu_result),
      .div_zero (alu_div_zero)
   );

   // Ops arriving while RUN (including the edge busy falls on) are dropped by construction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (md.start) begin
                  if (md_is_long(md.md_op)) begin
                     op_q   <= md.md_op;
                     a_q    <= md.rs_val;
                     b_q    <= md.rt_val;
                     state  <= ST_RUN;
                     busy_q <= 1'b1;
                     cnt    <= md_is_div(md.md_op) ? md_cnt_t'(DIV_CYCLES)
                                                   : md_cnt_t'(MULT_CYCLES);
                  end else if (md.md_op == MD_MTHI) begin
                     hi_q <= md.rs_val;
                  end else if (md.md_op == MD_MTLO) begin
                     lo_q <= md.rs_val;
                  end
               end
            end
            ST_RUN: begin
               if (cnt == md_cnt_t'(1)) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  cnt    <= '0;
                  // A zero divisor still burns the full latency but leaves HI/LO intact.
                  if (!(md_is_div(op_q) && alu_div_zero)) begin
                     hi_q <= alu_result[63:32];
                     lo_q <= alu_result[31:0];
                  end
               end else begin
                  cnt <= cnt - md_cnt_t'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign md.busy = busy_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl
module tb_md_ctrl;
   import md_pkg::*;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   md_ctrl_if bus ();

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic count_busy(output int cyc);
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = a;
      bus.rt_val = b;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rs_val = 32'hDEAD_BEEF;
      bus.rt_val = 32'h0000_0001;
      count_busy(cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_hi"}, bus.hi, exp_hi);
      check({tag, "_lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      int cyc;
      n_pass     = 0;
      n_total    = 0;
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.md_op  = 3'd0;
      bus.rs_val = 32'd0;
      bus.rt_val = 32'd0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("mthi", MD_MTHI, 32'h11, 32'd0, 0, 32'h11, 32'hFFFF_FFFD);
      run_op("mtlo", MD_MTLO, 32'h22, 32'd0, 0, 32'h11, 32'h22);
      run_op("div_zero", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
      run_op("invalid", 3'd7, 32'h99, 32'h98, 0, 32'h11, 32'h22);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
      run_op("mult_pos", MD_MULT, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);

      // start held through busy with different operands: only the first op lands
      @(negedge clk);
      bus.start  = 1'b1;
      bus.md_op  = MD_MULTU;
      bus.rs_val = 32'hFFFF_FFFF;
      bus.rt_val = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.md_op  = MD_MULT;
      bus.rs_val = 32'd2;
      bus.rt_val = 32'd3;
      count_busy(cyc);
      bus.start = 1'b0;
      check("b2b_cycles", 32'(cyc), 32'd5);
      check("b2b_hi", bus.hi, 32'hFFFF_FFFE);
      check("b2b_lo", bus.lo, 32'd1);
      @(negedge clk);
      check("b2b_no_retrig", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("b2b_hold_lo", bus.lo, 32'd1);

      // reset at busy cycle 4 of a divide
      @(negedge clk);
      bus.start  = 1'b1;
      bus.md_op  = MD_DIVU;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_hi", bus.hi, 32'd0);
      check("arst_lo", bus.lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("post_rst_hi", bus.hi, 32'd0);
      check("post_rst_lo", bus.lo, 32'd0);

      // start presented in the first clock after reset release
      reset = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.md_op  = MD_MULTU;
      bus.rs_val = 32'd6;
      bus.rt_val = 32'd7;
      reset      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      count_busy(cyc);
      check("first_clk_cycles", 32'(cyc), 32'd5);
      check("first_clk_lo", bus.lo, 32'd42);
      check("first_clk_hi", bus.hi, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request from E stage to issue md_op this cycle.
REQ-006 SHALL have port md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package encodings).
REQ-007 SHALL have port rs_val  input  32  first operand (dividend / multiplicand / MTHI-MTLO data).
REQ-008 SHALL have port rt_val  input  32  second operand (divisor / multiplier).
REQ-009 SHALL have port busy  output  1  registered; high while a MULT/DIV is in flight.
REQ-010 SHALL have port hi  output  32  HI register.
REQ-011 SHALL have port lo  output  32  LO register.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; a down-counter holds remaining cycles.
REQ-013 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch md_op, rs_val, rt_val, enter RUN, and load the counter with the op's cycle count.
REQ-014 busy SHALL be high for exactly MULT_CYCLES (or DIV_CYCLES) cycles, starting the edge after acceptance.
REQ-015 On the edge where the counter expires, the FSM SHALL return to IDLE, busy SHALL fall, and hi/lo SHALL update on that same edge.
REQ-016 MULT SHALL compute the signed 64-bit product; MULTU the unsigned one; hi = [63:32], lo = [31:0].
REQ-017 DIV/DIVU SHALL set lo = quotient and hi = remainder; signed quotient truncates toward zero, and the remainder takes the dividend's sign.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-019 Division by zero SHALL still run DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged.
REQ-020 MTHI/MTLO with start in IDLE SHALL write rs_val to hi/lo at the next edge, with no busy cycle.
REQ-021 start while busy SHALL be ignored; the hazard logic stalls the pipeline on busy and prevents this.
REQ-022 start in the same cycle busy falls SHALL be ignored; the first acceptable cycle is the one after busy is low.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.
REQ-024 An invalid md_op with start SHALL be a no-op.

Reset
REQ-025 reset low SHALL immediately force IDLE, busy = 0, counter = 0, hi = 0, lo = 0, with no clock needed.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no hi/lo writeback SHALL occur after reset releases.
REQ-027 After reset deasserts, a start in the first clock SHALL be accepted.

Structure
REQ-028 Package md_pkg SHALL hold the md_op encodings, the state enum and the default cycle counts.
REQ-029 Sub-module md_alu SHALL be a purely combinational 64-bit mult/div result generator fed from the latched operands; md_ctrl owns all sequencing and registers.

Verification
REQ-030 MULT: rs = 0xFFFFFFFE (-2), rt = 3, start 1 cycle -> busy high 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-031 DIVU: rs = 7, rt = 2 -> busy high 10 cycles; then lo = 3, hi = 1. DIV: rs = -7, rt = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-032 DIV by zero: preload via MTHI 0x11, MTLO 0x22; DIV rs = 5, rt = 0 -> busy 10 cycles; hi = 0x11, lo = 0x22.
REQ-033 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-034 Back-to-back: MULTU 0xFFFFFFFF x 0xFFFFFFFF, then start held during busy with other operands -> only the first result (hi = 0xFFFFFFFE, lo = 1) lands, and busy does not retrigger.
REQ-035 Reset mid-DIV at cycle 4 of busy -> busy, hi and lo are 0 immediately; they stay 0 after release with no late writeback.
